// File: rtl/noc_pkg.sv
// Shared NoC/memory-endpoint types and defaults.
// Request struct, FSM states and address-field helpers.
package noc_pkg;

    localparam int NOC_DATA_W    = 512;
    localparam int NOC_ADDR_W    = 32;
    localparam int NOC_TAG_W     = 1;
    localparam int NOC_MEM_WORDS = 256;
    localparam int NOC_IDX_W     = $clog2(NOC_MEM_WORDS);

    // Write flag sits in the address MSB, source tag just below it.
    localparam int NOC_WR_BIT = NOC_ADDR_W - 1;
    localparam int NOC_TAG_HI = NOC_ADDR_W - 2;

    typedef struct packed {
        logic                  write;
        logic [NOC_TAG_W-1:0]  tag;
        logic [NOC_IDX_W-1:0]  index;
        logic [NOC_DATA_W-1:0] data;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_e;

    function automatic int wr_bit(input int aw);
        return aw - 1;
    endfunction

    function automatic int tag_hi(input int aw);
        return aw - 2;
    endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Synchronous request FIFO; a full push is accepted only alongside a pop.
// Pointers and count reset asynchronously, storage is not reset.
module mem_resp_fifo
    import noc_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wptr_q;
    logic [AW-1:0]  rptr_q;
    logic [AW:0]    cnt_q;
    logic           wr;
    logic           rd;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rd      = pop_i && !empty_o;
    assign wr      = push_i && (!full_o || rd);
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + AW'(1);
            if (rd) rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory endpoint above the NoC root: queued in-order fixed-latency access.
// MEM_RESP_WRITE_ACK_EN: when defined, writes also return a response pulse.
module mem_responder
    import noc_pkg::*;
#(
    parameter int DATA_W     = NOC_DATA_W,
    parameter int ADDR_W     = NOC_ADDR_W,
    parameter int TAG_W      = NOC_TAG_W,
    parameter int MEM_WORDS  = NOC_MEM_WORDS,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_C2M_IN,
    input  logic [DATA_W-1:0] Data_C2M_IN,
    input  logic [ADDR_W-1:0] Addr_C2M_IN,
    output logic              en_M2C_OUT,
    output logic [DATA_W-1:0] Data_M2C_OUT,
    output logic [TAG_W:0]    AccessComplete_M2C_OUT,
    output logic              overflow
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WR_B  = wr_bit(ADDR_W);
    localparam int TAG_B = tag_hi(ADDR_W);
`ifdef MEM_RESP_WRITE_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    typedef struct packed {
        logic              write;
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              push_req;
    ent_t              head;
    ent_t              work_q;
    state_e            state_q;
    state_e            state_d;
    logic [CW-1:0]     cnt_q;
    logic              pop;
    logic              full;
    logic              empty;
    logic              acc_done;
    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic [DATA_W-1:0] data_q;
    logic [TAG_W:0]    ac_q;
    logic              ovf_q;
    logic              unused_addr;

    // Index bits above the array depth are dropped, so addresses alias.
    assign push_req = '{
        write: Addr_C2M_IN[WR_B],
        tag:   Addr_C2M_IN[TAG_B -: TAG_W],
        index: Addr_C2M_IN[IDX_W-1:0],
        data:  Data_C2M_IN
    };
    assign unused_addr = ^Addr_C2M_IN;

    mem_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (ent_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (en_C2M_IN),
        .wdata_i (push_req),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (!empty) state_d = S_ACCESS;
            S_ACCESS:  if (cnt_q == '0)
                           state_d = (work_q.write && !WR_ACK)
                                   ? S_IDLE : S_RESPOND;
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        acc_done   = 1'b0;
        en_M2C_OUT = 1'b0;
        unique case (state_q)
            S_IDLE:    pop        = !empty;
            S_ACCESS:  acc_done   = (cnt_q == '0);
            S_RESPOND: en_M2C_OUT = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            ac_q   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (pop) begin
                work_q <= head;
                cnt_q  <= CW'(MEM_LAT - 1);
            end else if (state_q == S_ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (acc_done && state_d == S_RESPOND) begin
                data_q <= work_q.write ? work_q.data : mem_q[work_q.index];
                ac_q   <= {work_q.tag, 1'b1};
            end
            if (en_C2M_IN && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_done && work_q.write) mem_q[work_q.index] <= work_q.data;
    end

    assign Data_M2C_OUT           = data_q;
    assign AccessComplete_M2C_OUT = ac_q;
    assign overflow               = ovf_q;

endmodule
